// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: branch types, FSM
// states, opcode constants and the branch-condition helper.
package fetch_pkg;

    localparam logic [2:0] BT_NONE = 3'd0;
    localparam logic [2:0] BT_BEQ  = 3'd1;
    localparam logic [2:0] BT_BNE  = 3'd2;
    localparam logic [2:0] BT_BLE  = 3'd3;
    localparam logic [2:0] BT_BLT  = 3'd4;
    localparam logic [2:0] BT_BNEZ = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h0;
    localparam logic [5:0] OP_J     = 6'h2;
    localparam logic [5:0] OP_JAL   = 6'h3;
    localparam logic [5:0] OP_BEQ   = 6'h4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

    // Unknown branch types fall through as not taken.
    function automatic logic branchTaken(input logic [2:0] bt, input logic zero, input logic neg);
        logic taken;
        case (bt)
            BT_BEQ:  taken = zero;
            BT_BNE:  taken = !zero;
            BT_BLE:  taken = zero | neg;
            BT_BLT:  taken = neg & !zero;
            BT_BNEZ: taken = !zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc_sel.sv
// Next-PC resolution: JR > jump > taken branch > sequential, with the
// selected target forced word-aligned and a misalignment indication.
module next_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic [25:0] i_instrField,
    input  logic        i_branch,
    input  logic [2:0]  i_branchType,
    input  logic        i_jump,
    input  logic        i_jr,
    input  logic [31:0] i_jrAddr,
    input  logic        i_aluZero,
    input  logic        i_aluNeg,
    output logic [31:0] o_nextPc,
    output logic        o_misalign
);

    logic [31:0] w_pc4;
    logic [31:0] w_jumpTarget;
    logic [31:0] w_branchTarget;
    logic [31:0] w_target;
    logic        w_taken;

    assign w_pc4          = i_pc + 32'd4;
    assign w_jumpTarget   = {w_pc4[31:28], i_instrField, 2'b00};
    assign w_branchTarget = w_pc4 + {{14{i_instrField[15]}}, i_instrField[15:0], 2'b00};
    assign w_taken        = i_branch && branchTaken(i_branchType, i_aluZero, i_aluNeg);

    always_comb begin
        w_target = w_pc4;
        if (i_jr) begin
            w_target = i_jrAddr;
        end else if (i_jump) begin
            w_target = w_jumpTarget;
        end else if (w_taken) begin
            w_target = w_branchTarget;
        end
    end

    assign o_nextPc   = {w_target[31:2], 2'b00};
    assign o_misalign = |w_target[1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, fetches one instruction at a time
// over a req/ack memory interface and issues it with a valid/ready handshake.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_ack_i,
    input  logic [31:0]      imem_data_i,
    output logic [31:0]      instr_o,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      link_pc_o,
    input  logic             branch_i,
    input  logic [2:0]       branch_type_i,
    input  logic             jump_i,
    input  logic             jr_i,
    input  logic [31:0]      jr_addr_i,
    input  logic             alu_zero_i,
    input  logic             alu_neg_i,
    output logic             misalign_o,
    output logic [CNT_W-1:0] retired_o
);

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_instr;
    logic             r_valid;
    logic             r_req;
    logic             r_misalign;
    logic [CNT_W-1:0] r_retired;
    logic [31:0]      w_nextPc;
    logic             w_misalign;

    next_pc_sel u_nextPcSel (
        .i_pc         (r_pc),
        .i_instrField (r_instr[25:0]),
        .i_branch     (branch_i),
        .i_branchType (branch_type_i),
        .i_jump       (jump_i),
        .i_jr         (jr_i),
        .i_jrAddr     (jr_addr_i),
        .i_aluZero    (alu_zero_i),
        .i_aluNeg     (alu_neg_i),
        .o_nextPc     (w_nextPc),
        .o_misalign   (w_misalign)
    );

    // Outputs are registered alongside the state so req/valid never glitch;
    // a late ack after reset lands in IDLE and is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= 32'd0;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
            r_misalign <= 1'b0;
            r_retired  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_REQ;
                    r_req   <= 1'b1;
                end
                ST_REQ, ST_WAIT: begin
                    if (imem_ack_i) begin
                        r_instr <= imem_data_i;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_ISSUE: begin
                    if (instr_ready_i) begin
                        r_pc       <= w_nextPc;
                        r_misalign <= r_misalign | w_misalign;
                        r_retired  <= r_retired + CNT_W'(1);
                        r_valid    <= 1'b0;
                        r_req      <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_pc;
    assign instr_o       = r_instr;
    assign instr_valid_o = r_valid;
    assign pc_o          = r_pc;
    assign link_pc_o     = r_pc + 32'd4;
    assign misalign_o    = r_misalign;
    assign retired_o     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against a behavioural
// next-PC / counter model; retired counter narrowed to 4 bits to exercise wrap.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CNT_W    = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             imem_req_o;
    logic [31:0]      imem_addr_o;
    logic             imem_ack_i;
    logic [31:0]      imem_data_i;
    logic [31:0]      instr_o;
    logic             instr_valid_o;
    logic             instr_ready_i;
    logic [31:0]      pc_o;
    logic [31:0]      link_pc_o;
    logic             branch_i;
    logic [2:0]       branch_type_i;
    logic             jump_i;
    logic             jr_i;
    logic [31:0]      jr_addr_i;
    logic             alu_zero_i;
    logic             alu_neg_i;
    logic             misalign_o;
    logic [CNT_W-1:0] retired_o;

    int          vectorCount = 0;
    int          failCount   = 0;
    logic [31:0] mPc;
    logic [31:0] mInstr;
    int          mRetired;
    logic        mMisalign;

    fetch_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .pc_o          (pc_o),
        .link_pc_o     (link_pc_o),
        .branch_i      (branch_i),
        .branch_type_i (branch_type_i),
        .jump_i        (jump_i),
        .jr_i          (jr_i),
        .jr_addr_i     (jr_addr_i),
        .alu_zero_i    (alu_zero_i),
        .alu_neg_i     (alu_neg_i),
        .misalign_o    (misalign_o),
        .retired_o     (retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference next-PC target, before alignment, from the architectural rules.
    function automatic logic [31:0] modelTarget(input logic [31:0] pc, input logic [31:0] instr,
                                                input logic br, input logic [2:0] bt, input logic j,
                                                input logic jr, input logic [31:0] jrAddr,
                                                input logic z, input logic n);
        logic [31:0] pc4;
        logic        taken;
        int          offset;
        pc4   = pc + 32'd4;
        taken = 1'b0;
        if (br) begin
            if (bt == 3'd1) taken = z;
            if (bt == 3'd2) taken = !z;
            if (bt == 3'd3) taken = z || n;
            if (bt == 3'd4) taken = n && !z;
            if (bt == 3'd5) taken = !z;
        end
        offset = int'($signed(instr[15:0])) * 4;
        if (jr) return jrAddr;
        if (j) return (pc4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 32'd4);
        if (taken) return pc4 + 32'(offset);
        return pc4;
    endfunction

    task automatic scrambleControls();
        branch_i      = 1'($urandom_range(0, 1));
        branch_type_i = 3'($urandom_range(0, 7));
        jump_i        = 1'($urandom_range(0, 1));
        jr_i          = 1'($urandom_range(0, 1));
        jr_addr_i     = $urandom;
        alu_zero_i    = 1'($urandom_range(0, 1));
        alu_neg_i     = 1'($urandom_range(0, 1));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "Valid"}, 32'(instr_valid_o), 32'd0);
        checkOutput({tag, "Req"}, 32'(imem_req_o), 32'd0);
        checkOutput({tag, "Pc"}, pc_o, RESET_PC);
        checkOutput({tag, "Link"}, link_pc_o, RESET_PC + 32'd4);
        checkOutput({tag, "Instr"}, instr_o, 32'd0);
        checkOutput({tag, "Retired"}, 32'(retired_o), 32'd0);
        checkOutput({tag, "Misalign"}, 32'(misalign_o), 32'd0);
    endtask

    task automatic resetModel();
        mPc       = RESET_PC;
        mInstr    = 32'd0;
        mRetired  = 0;
        mMisalign = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_i         = 1'b0;
        imem_ack_i    = 1'b0;
        instr_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkResetState("reset");
        rst_i = 1'b1;
        resetModel();
    endtask

    task automatic waitForReq();
        int n;
        n = 0;
        while (!imem_req_o && n < 4) begin
            @(negedge clk_i);
            n++;
        end
        if (!imem_req_o) checkOutput("reqTimeout", 32'(imem_req_o), 32'd1);
    endtask

    // One full instruction: fetch with ackDelay wait cycles, hold in ISSUE for
    // readyDelay cycles, then accept with the given control inputs.
    task automatic applyStimulus(input int ackDelay, input logic [31:0] data, input int readyDelay,
                                 input logic br, input logic [2:0] bt, input logic j,
                                 input logic jr, input logic [31:0] jrAddr,
                                 input logic z, input logic n);
        logic [31:0] target;
        waitForReq();
        checkOutput("reqAddr", imem_addr_o, mPc);
        for (int i = 0; i < ackDelay; i++) begin
            scrambleControls();
            imem_ack_i    = 1'b0;
            imem_data_i   = $urandom;
            instr_ready_i = 1'($urandom_range(0, 1));
            @(negedge clk_i);
            checkOutput("waitReq", 32'(imem_req_o), 32'd1);
            checkOutput("waitAddr", imem_addr_o, mPc);
            checkOutput("waitInstr", instr_o, mInstr);
            checkOutput("waitValid", 32'(instr_valid_o), 32'd0);
        end
        scrambleControls();
        imem_ack_i    = 1'b1;
        imem_data_i   = data;
        instr_ready_i = 1'($urandom_range(0, 1));
        @(negedge clk_i);
        imem_ack_i    = 1'b0;
        imem_data_i   = $urandom;
        instr_ready_i = 1'b0;
        mInstr        = data;
        checkOutput("issueValid", 32'(instr_valid_o), 32'd1);
        checkOutput("issueInstr", instr_o, data);
        checkOutput("issueReq", 32'(imem_req_o), 32'd0);
        for (int i = 0; i < readyDelay; i++) begin
            scrambleControls();
            @(negedge clk_i);
            checkOutput("holdValid", 32'(instr_valid_o), 32'd1);
            checkOutput("holdInstr", instr_o, data);
            checkOutput("holdPc", pc_o, mPc);
        end
        branch_i      = br;
        branch_type_i = bt;
        jump_i        = j;
        jr_i          = jr;
        jr_addr_i     = jrAddr;
        alu_zero_i    = z;
        alu_neg_i     = n;
        instr_ready_i = 1'b1;
        checkOutput("linkPc", link_pc_o, mPc + 32'd4);
        target    = modelTarget(mPc, data, br, bt, j, jr, jrAddr, z, n);
        mPc       = target & 32'hFFFF_FFFC;
        mMisalign = mMisalign | (target[1:0] != 2'b00);
        mRetired  = (mRetired + 1) % (1 << CNT_W);
        @(negedge clk_i);
        instr_ready_i = 1'b0;
        scrambleControls();
        checkOutput("acceptPc", pc_o, mPc);
        checkOutput("acceptRetired", 32'(retired_o), 32'(mRetired));
        checkOutput("acceptMisalign", 32'(misalign_o), 32'(mMisalign));
        checkOutput("acceptValid", 32'(instr_valid_o), 32'd0);
    endtask

    task automatic jumpTo(input logic [31:0] addr);
        applyStimulus(0, $urandom, 0, 1'b0, 3'd0, 1'b0, 1'b1, addr, 1'b0, 1'b0);
    endtask

    task automatic randomInstr();
        applyStimulus($urandom_range(0, 3), $urandom, $urandom_range(0, 2),
                      1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 7) == 0), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        rst_i         = 1'b0;
        imem_ack_i    = 1'b0;
        imem_data_i   = 32'd0;
        instr_ready_i = 1'b0;
        branch_i      = 1'b0;
        branch_type_i = 3'd0;
        jump_i        = 1'b0;
        jr_i          = 1'b0;
        jr_addr_i     = 32'd0;
        alu_zero_i    = 1'b0;
        alu_neg_i     = 1'b0;
        resetModel();

        doReset();
        applyStimulus(0, 32'h2008_0005, 0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(3, 32'h1234_5678, 1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // BEQ backwards taken, then not taken.
        jumpTo(32'h10);
        applyStimulus(0, {6'h4, 5'd1, 5'd2, 16'hFFFE}, 0, 1'b1, 3'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        jumpTo(32'h10);
        applyStimulus(1, {6'h4, 5'd1, 5'd2, 16'hFFFE}, 0, 1'b1, 3'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // jal, then jr beating jump.
        jumpTo(32'h40);
        applyStimulus(0, {6'h3, 26'h10}, 0, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        applyStimulus(0, {6'h3, 26'h10}, 0, 1'b0, 3'd0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0);

        // BLT with zero and negative both set is not taken.
        applyStimulus(0, {6'h4, 5'd1, 5'd2, 16'h0010}, 0, 1'b1, 3'd4, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

        // PC wrap from the top of the address space.
        jumpTo(32'hFFFF_FFFC);
        applyStimulus(0, 32'h0000_0000, 0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

        // Misaligned JR target; the flag must stick through later instructions.
        jumpTo(32'h102);
        for (int k = 0; k < 30; k++) randomInstr();

        // Reset while waiting, with ack arriving on the reset edge.
        waitForReq();
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        checkOutput("midWaitReq", 32'(imem_req_o), 32'd1);
        rst_i       = 1'b0;
        imem_ack_i  = 1'b1;
        imem_data_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        checkResetState("midReset");
        imem_ack_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        resetModel();

        for (int k = 0; k < 20; k++) randomInstr();

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
